// File: rtl/wb_pkg.sv
// Shared widths, bank encoding and requester indices for the writeback controller.
package wb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int NREG   = 2 ** ADDR_W;

    typedef enum logic {
        BANK_S = 1'b0,
        BANK_V = 1'b1
    } bank_e;

    localparam int REQ_SCALAR = 0;
    localparam int REQ_VECTOR = 1;

endpackage

// File: rtl/wb_rr_arbiter.sv
// 2-way round-robin arbiter; grant is combinational, last_grant_q updates on a grant.
// A lone requester always wins; on contention the one not granted last time wins.
module wb_rr_arbiter
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (|grant) begin
            last_grant_d = grant[REQ_VECTOR];
        end
    end

    // Reset to the vector side so the scalar path wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/wb_hazard_ctrl.sv
// Shared scalar/vector register-file write port with RAW/WAW scoreboard; request to write enable is 1 cycle.
// Requesters hold until req_ready; ID is held by a combinational stall while a needed register is pending.
module wb_hazard_ctrl #(
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int NREG   = wb_pkg::NREG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_vec,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          req_ready,
    output logic [ADDR_W-1:0]   writeAddr,
    output logic [DATA_W-1:0]   writeData,
    output logic                RegWrite,
    output logic                VRegWrite,
    input  logic                rsv_valid,
    input  logic                rsv_vec,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic                rs1_vec,
    input  logic                rs2_vec,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic [ADDR_W-1:0]   rs2,
    input  logic [1:0]          rs_used,
    output logic                stall,
    output logic                idle
);

    import wb_pkg::*;

    logic [1:0]        grant;
    logic              g_any;
    logic              g_vec;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;

    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              reg_write_q, reg_write_d;
    logic              vreg_write_q, vreg_write_d;
    logic [NREG-1:0]   pending_s_q, pending_s_d;
    logic [NREG-1:0]   pending_v_q, pending_v_d;

    logic              pend_rs1;
    logic              pend_rs2;
    logic              pend_rsv;
    logic              rsv_take;

    wb_rr_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .grant     (grant)
    );

    always_comb begin
        g_any  = |grant;
        g_vec  = grant[REQ_VECTOR] ? req_vec[REQ_VECTOR] : req_vec[REQ_SCALAR];
        g_addr = grant[REQ_VECTOR] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        g_data = grant[REQ_VECTOR] ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    end

    // Pending bits stay visible during the write-enable cycle, so a reader waits for the commit.
    always_comb begin
        pend_rs1 = (rs1_vec == BANK_V) ? pending_v_q[rs1]
                                       : ((rs1 != '0) && pending_s_q[rs1]);
        pend_rs2 = (rs2_vec == BANK_V) ? pending_v_q[rs2]
                                       : ((rs2 != '0) && pending_s_q[rs2]);
        pend_rsv = (rsv_vec == BANK_V) ? pending_v_q[rsv_addr]
                                       : ((rsv_addr != '0) && pending_s_q[rsv_addr]);
        stall    = (rs_used[0] & pend_rs1) | (rs_used[1] & pend_rs2) | (rsv_valid & pend_rsv);
        rsv_take = rsv_valid & ~stall & ~((rsv_vec == BANK_S) && (rsv_addr == '0));
    end

    // Clear first, then set, so a new producer on the retiring register keeps its bit.
    always_comb begin
        pending_s_d = pending_s_q;
        pending_v_d = pending_v_q;
        if (reg_write_q) begin
            pending_s_d[write_addr_q] = 1'b0;
        end
        if (vreg_write_q) begin
            pending_v_d[write_addr_q] = 1'b0;
        end
        if (rsv_take) begin
            if (rsv_vec == BANK_V) begin
                pending_v_d[rsv_addr] = 1'b1;
            end else begin
                pending_s_d[rsv_addr] = 1'b1;
            end
        end
    end

    // Scalar r0 writes are consumed without an enable.
    always_comb begin
        reg_write_d  = g_any & ~g_vec & (g_addr != '0);
        vreg_write_d = g_any & g_vec;
        write_addr_d = g_any ? g_addr : write_addr_q;
        write_data_d = g_any ? g_data : write_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_addr_q <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
            vreg_write_q <= 1'b0;
            pending_s_q  <= '0;
            pending_v_q  <= '0;
        end else begin
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            vreg_write_q <= vreg_write_d;
            pending_s_q  <= pending_s_d;
            pending_v_q  <= pending_v_d;
        end
    end

    assign req_ready = grant;
    assign writeAddr = write_addr_q;
    assign writeData = write_data_q;
    assign RegWrite  = reg_write_q;
    assign VRegWrite = vreg_write_q;
    assign idle      = ~(|pending_s_q) & ~(|pending_v_q) & ~reg_write_q & ~vreg_write_q;

endmodule

// File: tb/tb_wb_hazard_ctrl.sv
// Directed scenarios plus randomized traffic checked against an array-based scoreboard model.
module tb_wb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_vec, req_ready, rs_used;
    logic [7:0]  req_addr;
    logic [63:0] req_data;
    logic [3:0]  writeAddr, rsv_addr, rs1, rs2;
    logic [31:0] writeData;
    logic        RegWrite, VRegWrite, rsv_valid, rsv_vec, rs1_vec, rs2_vec, stall, idle;

    int nchk = 0;
    int nerr = 0;

    // Reference model state
    bit          ps[16];
    bit          pv[16];
    int          lg;
    bit          m_rw, m_vrw;
    logic [3:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    wb_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_vec(req_vec), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .writeAddr(writeAddr), .writeData(writeData),
        .RegWrite(RegWrite), .VRegWrite(VRegWrite),
        .rsv_valid(rsv_valid), .rsv_vec(rsv_vec), .rsv_addr(rsv_addr),
        .rs1_vec(rs1_vec), .rs2_vec(rs2_vec), .rs1(rs1), .rs2(rs2), .rs_used(rs_used),
        .stall(stall), .idle(idle)
    );

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            ps[i] = 1'b0;
            pv[i] = 1'b0;
        end
        lg = 1; m_rw = 1'b0; m_vrw = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_vec = '0; req_addr = '0; req_data = '0;
        rsv_valid = 1'b0; rsv_vec = 1'b0; rsv_addr = '0;
        rs1_vec = 1'b0; rs2_vec = 1'b0; rs1 = '0; rs2 = '0; rs_used = '0;
    endtask

    function automatic logic [1:0] exp_grant();
        if (req_valid == 2'b11) return (lg == 0) ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    function automatic bit mpend(bit vec, int a);
        if (vec) return pv[a];
        if (a == 0) return 1'b0;
        return ps[a];
    endfunction

    function automatic bit exp_stall();
        return (rs_used[0] && mpend(rs1_vec, int'(rs1))) ||
               (rs_used[1] && mpend(rs2_vec, int'(rs2))) ||
               (rsv_valid && mpend(rsv_vec, int'(rsv_addr)));
    endfunction

    function automatic bit exp_idle();
        bit any = m_rw || m_vrw;
        for (int i = 0; i < 16; i++) any = any || ps[i] || pv[i];
        return !any;
    endfunction

    // Advance one clock: DUT and model both see the inputs present before the edge.
    task automatic tick();
        logic [1:0] g;
        bit st;
        int idx;
        g  = exp_grant();
        st = exp_stall();
        @(posedge clk);
        if (m_rw)  ps[m_addr] = 1'b0;
        if (m_vrw) pv[m_addr] = 1'b0;
        if (rsv_valid && !st && !(rsv_vec == 1'b0 && rsv_addr == 4'd0)) begin
            if (rsv_vec) pv[rsv_addr] = 1'b1;
            else         ps[rsv_addr] = 1'b1;
        end
        if (g != 2'b00) begin
            idx    = g[1] ? 1 : 0;
            lg     = idx;
            m_addr = idx ? req_addr[7:4] : req_addr[3:0];
            m_data = idx ? req_data[63:32] : req_data[31:0];
            m_vrw  = req_vec[idx];
            m_rw   = !req_vec[idx] && (m_addr != 4'd0);
        end else begin
            m_rw  = 1'b0;
            m_vrw = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #3;
        nchk++; if (RegWrite !== 1'b0)  begin nerr++; $display("FAIL reset_regwrite got %b want 0", RegWrite); end
        nchk++; if (VRegWrite !== 1'b0) begin nerr++; $display("FAIL reset_vregwrite got %b want 0", VRegWrite); end
        nchk++; if (writeAddr !== 4'd0) begin nerr++; $display("FAIL reset_addr got %h want 0", writeAddr); end
        nchk++; if (writeData !== 32'd0) begin nerr++; $display("FAIL reset_data got %h want 0", writeData); end
        nchk++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL reset_ready got %b want 00", req_ready); end
        nchk++; if (idle !== 1'b1)      begin nerr++; $display("FAIL reset_idle got %b want 1", idle); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_valid = 2'b01; req_vec = 2'b00; req_addr = {4'd0, 4'd5}; req_data = {32'd0, 32'hDEADBEEF};
        #1;
        nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL single_ready got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        nchk++; if (RegWrite !== 1'b1)  begin nerr++; $display("FAIL single_regwrite got %b want 1", RegWrite); end
        nchk++; if (VRegWrite !== 1'b0) begin nerr++; $display("FAIL single_vregwrite got %b want 0", VRegWrite); end
        nchk++; if (writeAddr !== 4'd5) begin nerr++; $display("FAIL single_addr got %h want 5", writeAddr); end
        nchk++; if (writeData !== 32'hDEADBEEF) begin nerr++; $display("FAIL single_data got %h want deadbeef", writeData); end
        tick();
        nchk++; if (RegWrite !== 1'b0) begin nerr++; $display("FAIL single_pulse got %b want 0", RegWrite); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] want [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        req_valid = 2'b11; req_vec = 2'b10; req_addr = {4'd2, 4'd1}; req_data = {32'hB0B0_0002, 32'hA0A0_0001};
        for (int i = 0; i < 4; i++) begin
            #1;
            nchk++; if (req_ready !== want[i]) begin nerr++; $display("FAIL b2b_grant%0d got %b want %b", i, req_ready, want[i]); end
            tick();
            nchk++; if (VRegWrite !== ((i % 2) == 1)) begin nerr++; $display("FAIL b2b_vwe%0d got %b", i, VRegWrite); end
            nchk++; if (RegWrite !== ((i % 2) == 0))  begin nerr++; $display("FAIL b2b_we%0d got %b", i, RegWrite); end
            nchk++; if (writeAddr !== (((i % 2) == 1) ? 4'd2 : 4'd1)) begin nerr++; $display("FAIL b2b_addr%0d got %h", i, writeAddr); end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_raw_stall();
        rsv_valid = 1'b1; rsv_vec = 1'b1; rsv_addr = 4'd3;
        #1;
        nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL raw_rsv_stall got %b want 0", stall); end
        tick();
        rsv_valid = 1'b0; rs1_vec = 1'b1; rs1 = 4'd3; rs_used = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            nchk++; if (stall !== 1'b1) begin nerr++; $display("FAIL raw_wait%0d got %b want 1", i, stall); end
            tick();
        end
        req_valid = 2'b10; req_vec = 2'b10; req_addr = {4'd3, 4'd0}; req_data = {32'h0000_3333, 32'd0};
        tick();
        req_valid = 2'b00;
        nchk++; if (VRegWrite !== 1'b1) begin nerr++; $display("FAIL raw_vwe got %b want 1", VRegWrite); end
        nchk++; if (stall !== 1'b1)     begin nerr++; $display("FAIL raw_stall_wecycle got %b want 1", stall); end
        tick();
        nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL raw_release got %b want 0", stall); end
        nchk++; if (idle !== 1'b1)  begin nerr++; $display("FAIL raw_idle got %b want 1", idle); end
        rs_used = 2'b00;
    endtask

    task automatic test_waw();
        rsv_valid = 1'b1; rsv_vec = 1'b0; rsv_addr = 4'd7;
        tick();
        nchk++; if (stall !== 1'b1) begin nerr++; $display("FAIL waw_stall got %b want 1", stall); end
        tick();
        nchk++; if (idle !== 1'b0) begin nerr++; $display("FAIL waw_idle got %b want 0", idle); end
        req_valid = 2'b01; req_vec = 2'b00; req_addr = {4'd0, 4'd7}; req_data = {32'd0, 32'h7777_7777};
        tick();
        req_valid = 2'b00;
        nchk++; if (RegWrite !== 1'b1) begin nerr++; $display("FAIL waw_we got %b want 1", RegWrite); end
        nchk++; if (stall !== 1'b1)    begin nerr++; $display("FAIL waw_stall_wecycle got %b want 1", stall); end
        tick();
        nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL waw_accept got %b want 0", stall); end
        tick();
        rsv_valid = 1'b0; rs1_vec = 1'b0; rs1 = 4'd7; rs_used = 2'b01;
        #1;
        nchk++; if (stall !== 1'b1) begin nerr++; $display("FAIL waw_repending got %b want 1", stall); end
        rs_used = 2'b00;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        nchk++; if (idle !== 1'b1) begin nerr++; $display("FAIL waw_drain got %b want 1", idle); end
    endtask

    task automatic test_same_edge();
        req_valid = 2'b01; req_vec = 2'b00; req_addr = {4'd0, 4'd4}; req_data = {32'd0, 32'h4444_0004};
        tick();
        req_valid = 2'b00;
        rsv_valid = 1'b1; rsv_vec = 1'b0; rsv_addr = 4'd4;
        #1;
        nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL same_stall got %b want 0", stall); end
        tick();
        rsv_valid = 1'b0; rs1_vec = 1'b0; rs1 = 4'd4; rs_used = 2'b01;
        #1;
        nchk++; if (idle !== 1'b0)  begin nerr++; $display("FAIL same_idle got %b want 0", idle); end
        nchk++; if (stall !== 1'b1) begin nerr++; $display("FAIL same_pending got %b want 1", stall); end
        rs_used = 2'b00;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        nchk++; if (idle !== 1'b1) begin nerr++; $display("FAIL same_drain got %b want 1", idle); end
    endtask

    task automatic test_r0_and_reset();
        req_valid = 2'b01; req_vec = 2'b00; req_addr = '0; req_data = {32'd0, 32'hFFFF_FFFF};
        #1;
        nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL r0_ready got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        nchk++; if (RegWrite !== 1'b0) begin nerr++; $display("FAIL r0_we got %b want 0", RegWrite); end
        nchk++; if (idle !== 1'b1)     begin nerr++; $display("FAIL r0_idle got %b want 1", idle); end
        rsv_valid = 1'b1; rsv_vec = 1'b0; rsv_addr = 4'd0; rs_used = 2'b11;
        #1;
        nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL r0_stall got %b want 0", stall); end
        tick();
        rsv_vec = 1'b1; rsv_addr = 4'd5; rs_used = 2'b00;
        nchk++; if (idle !== 1'b1) begin nerr++; $display("FAIL r0_unreserved got %b want 1", idle); end
        tick();
        rsv_valid = 1'b0;
        req_valid = 2'b10; req_vec = 2'b10; req_addr = {4'd5, 4'd0}; req_data = {32'h5555_5555, 32'd0};
        tick();
        req_valid = 2'b00;
        nchk++; if (VRegWrite !== 1'b1) begin nerr++; $display("FAIL rst_pre_vwe got %b want 1", VRegWrite); end
        #2;
        rst_n = 1'b0;
        #1;
        nchk++; if (VRegWrite !== 1'b0) begin nerr++; $display("FAIL rst_vwe got %b want 0", VRegWrite); end
        nchk++; if (RegWrite !== 1'b0)  begin nerr++; $display("FAIL rst_we got %b want 0", RegWrite); end
        nchk++; if (idle !== 1'b1)      begin nerr++; $display("FAIL rst_idle got %b want 1", idle); end
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        nchk++; if (idle !== 1'b1) begin nerr++; $display("FAIL rst_after got %b want 1", idle); end
    endtask

    task automatic test_random();
        logic [1:0] g;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && ($urandom_range(0, 1) == 1)) begin
                    req_valid[r] = 1'b1;
                    req_vec[r]   = 1'($urandom_range(0, 1));
                    if (r == 0) begin
                        req_addr[3:0]  = 4'($urandom_range(0, 7));
                        req_data[31:0] = $urandom;
                    end else begin
                        req_addr[7:4]   = 4'($urandom_range(0, 7));
                        req_data[63:32] = $urandom;
                    end
                end
            end
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_vec   = 1'($urandom_range(0, 1));
            rsv_addr  = 4'($urandom_range(0, 7));
            rs1_vec   = 1'($urandom_range(0, 1));
            rs2_vec   = 1'($urandom_range(0, 1));
            rs1       = 4'($urandom_range(0, 7));
            rs2       = 4'($urandom_range(0, 7));
            rs_used   = 2'($urandom_range(0, 3));
            #1;
            g = exp_grant();
            nchk++; if (req_ready !== g) begin nerr++; $display("FAIL rnd_ready c%0d got %b want %b", c, req_ready, g); end
            nchk++; if (stall !== exp_stall()) begin nerr++; $display("FAIL rnd_stall c%0d got %b want %b", c, stall, exp_stall()); end
            tick();
            req_valid = req_valid & ~g;
            nchk++; if (RegWrite !== m_rw)   begin nerr++; $display("FAIL rnd_we c%0d got %b want %b", c, RegWrite, m_rw); end
            nchk++; if (VRegWrite !== m_vrw) begin nerr++; $display("FAIL rnd_vwe c%0d got %b want %b", c, VRegWrite, m_vrw); end
            nchk++; if (idle !== exp_idle()) begin nerr++; $display("FAIL rnd_idle c%0d got %b want %b", c, idle, exp_idle()); end
            if (m_rw || m_vrw) begin
                nchk++; if (writeAddr !== m_addr) begin nerr++; $display("FAIL rnd_addr c%0d got %h want %h", c, writeAddr, m_addr); end
                nchk++; if (writeData !== m_data) begin nerr++; $display("FAIL rnd_data c%0d got %h want %h", c, writeData, m_data); end
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_raw_stall();
        test_waw();
        test_same_edge();
        test_r0_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
